// File: rtl/elink_tx_arbiter.sv
// elink_tx_arbiter: round-robin transmit arbiter for one e-link.
// It grants one channel for a whole frame and emits comma idle words
// between frames and while starved. One symbol is moved per tx_strobe.
module elink_tx_arbiter #(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 10,
    parameter int IDLE_GAP     = 2,
    parameter int UNDERRUN_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*DATA_W-1:0]     ch_data_in,
    input  logic [N_CH-1:0]            ch_valid,
    input  logic [N_CH-1:0]            ch_last,
    output logic [N_CH-1:0]            ch_ready,
    input  logic                       tx_strobe,
    input  logic [7:0]                 kchar_comma,
    output logic [DATA_W-1:0]          data_tra_out,
    output logic [$clog2(N_CH)-1:0]    grant_id,
    output logic                       busy,
    output logic                       underrun_err
);

    localparam int GW = $clog2(N_CH);
    localparam logic [3:0] GAP_C     = 4'(IDLE_GAP);
    localparam logic [7:0] UND_MAX_C = 8'(UNDERRUN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [3:0]          gap_q, gap_d;
    logic [7:0]          und_q, und_d;
    logic                busy_q;
    logic                err_q, err_d;
    logic [N_CH-1:0]     ready_s;
    logic                rr_hit_s;
    logic [GW-1:0]       rr_idx_s;
    logic [DATA_W-1:0]   idle_s;
    int                  cand_s;

    // Idle word: all ones above the low byte, comma character below.
    function automatic logic [DATA_W-1:0] idle_word(input logic [7:0] k);
        logic [DATA_W-1:0] w;
        w      = '1;
        w[7:0] = k;
        return w;
    endfunction

    assign idle_s = idle_word(kchar_comma);

    // Round-robin search: first valid channel after the last grant, wrapping.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_idx_s = grant_q;
        cand_s   = 0;
        for (int k = N_CH; k >= 1; k--) begin
            cand_s = (int'(grant_q) + k) % N_CH;
            if (ch_valid[cand_s]) begin
                rr_hit_s = 1'b1;
                rr_idx_s = cand_s[GW-1:0];
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
    end

    // Next-state, next-output and combinational ready generation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        gap_d   = gap_q;
        und_d   = und_q;
        err_d   = 1'b0;
        ready_s = '0;
        if (rst) begin
            state_d = ST_IDLE;
        end else if (tx_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (rr_hit_s) begin
                        ready_s[rr_idx_s] = 1'b1;
                        data_d  = ch_data_in[int'(rr_idx_s)*DATA_W +: DATA_W];
                        grant_d = rr_idx_s;
                        und_d   = 8'd0;
                        gap_d   = 4'd0;
                        if (!ch_last[rr_idx_s]) begin
                            state_d = ST_SEND;
                        end else if (IDLE_GAP == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        data_d = idle_s;
                    end
                end
                ST_SEND: begin
                    if (ch_valid[grant_q]) begin
                        ready_s[grant_q] = 1'b1;
                        data_d = ch_data_in[int'(grant_q)*DATA_W +: DATA_W];
                        und_d  = 8'd0;
                        if (!ch_last[grant_q]) begin
                            state_d = ST_SEND;
                        end else if (IDLE_GAP == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        data_d = idle_s;
                        if (und_q + 8'd1 == UND_MAX_C) begin
                            err_d = 1'b1;
                            und_d = 8'd0;
                            gap_d = 4'd0;
                            if (IDLE_GAP == 0) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            und_d = und_q + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    data_d = idle_s;
                    if (gap_q + 4'd1 >= GAP_C) begin
                        gap_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = idle_s;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= idle_s;
            grant_q <= GW'(N_CH - 1);
            gap_q   <= 4'd0;
            und_q   <= 8'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
            und_q   <= und_d;
            busy_q  <= (state_d == ST_SEND);
            err_q   <= err_d;
        end
    end

    assign ch_ready     = ready_s;
    assign data_tra_out = data_q;
    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign underrun_err = err_q;

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// Self-checking bench for elink_tx_arbiter: a directed vector table,
// hand-written corner sequences and randomized traffic against a
// frame-level reference model.
module tb_elink_tx_arbiter;

    localparam int N    = 4;
    localparam int W    = 10;
    localparam int GAP  = 2;
    localparam int UMAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, tx_strobe;
    logic [N-1:0]   ch_valid, ch_last, ch_ready;
    logic [N*W-1:0] ch_data_in;
    logic [7:0]     kchar;
    logic [W-1:0]   dout;
    logic [1:0]     gid;
    logic           busy, uerr;

    elink_tx_arbiter #(.N_CH(N), .DATA_W(W), .IDLE_GAP(GAP), .UNDERRUN_MAX(UMAX)) dut (
        .clk(clk), .rst(rst), .ch_data_in(ch_data_in), .ch_valid(ch_valid),
        .ch_last(ch_last), .ch_ready(ch_ready), .tx_strobe(tx_strobe),
        .kchar_comma(kchar), .data_tra_out(dout), .grant_id(gid),
        .busy(busy), .underrun_err(uerr)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: frame owner (-1 = none), commas still owed, starved strobes.
    int           m_owner = -1;
    int           m_gap = 0;
    int           m_starve = 0;
    int           m_grant = N - 1;
    logic [W-1:0] m_data;
    logic         m_busy, m_err;
    logic [N-1:0] cap_ready;

    logic [W-1:0] q_sym  [N][$];
    bit           q_last [N][$];

    typedef struct {
        logic r, s;
        logic [3:0] v, l;
        logic [39:0] d;
        logic [3:0] rdy;
        logic [9:0] dout;
        logic [1:0] gid;
        logic busy, err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, input logic [3:0] v, l,
                                input logic [39:0] d, input logic [3:0] rdy,
                                input logic [9:0] o, input logic [1:0] g,
                                input logic b, e);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.l = l; t.d = d;
        t.rdy = rdy; t.dout = o; t.gid = g; t.busy = b; t.err = e;
        return t;
    endfunction

    function automatic logic [W-1:0] idle_of(input logic [7:0] k);
        logic [W-1:0] w;
        w = '1;
        w[7:0] = k;
        return w;
    endfunction

    function automatic logic [W-1:0] sym(input int c);
        return ch_data_in[c*W +: W];
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_grant + k) % N;
            if (ch_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst || !tx_strobe) return r;
        if (m_owner >= 0) begin
            if (ch_valid[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        if (m_gap > 0) return r;
        g = rr_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic m_advance();
        int g;
        if (rst) begin
            m_owner = -1; m_gap = 0; m_starve = 0; m_grant = N - 1;
            m_data = idle_of(kchar); m_busy = 1'b0; m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (tx_strobe) begin
            if (m_owner >= 0) begin
                if (ch_valid[m_owner]) begin
                    m_data = sym(m_owner);
                    m_starve = 0;
                    if (ch_last[m_owner]) begin
                        m_owner = -1;
                        m_gap = GAP;
                    end
                end else begin
                    m_data = idle_of(kchar);
                    m_starve++;
                    if (m_starve == UMAX) begin
                        m_err = 1'b1; m_owner = -1; m_gap = GAP; m_starve = 0;
                    end
                end
            end else if (m_gap > 0) begin
                m_data = idle_of(kchar);
                m_gap--;
            end else begin
                g = rr_pick();
                if (g < 0) begin
                    m_data = idle_of(kchar);
                end else begin
                    m_grant = g;
                    m_data = sym(g);
                    m_starve = 0;
                    if (ch_last[g]) m_gap = GAP;
                    else m_owner = g;
                end
            end
        end
        m_busy = (m_owner >= 0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready before the edge, outputs after.
    task automatic drive(input logic r, s, input logic [N-1:0] v, l, input logic [N*W-1:0] d);
        rst = r; tx_strobe = s; ch_valid = v; ch_last = l; ch_data_in = d;
        #1;
        cap_ready = ch_ready;
        chk("ready", {12'd0, cap_ready}, {12'd0, m_ready()});
        @(posedge clk);
        m_advance();
        #1;
        chk("dout", {6'd0, dout}, {6'd0, m_data});
        chk("grant", {14'd0, gid}, 16'(m_grant));
        chk("busy", {15'd0, busy}, {15'd0, m_busy});
        chk("uerr", {15'd0, uerr}, {15'd0, m_err});
    endtask

    // Cycle driven from the per-channel source queues; accepted symbols are popped.
    task automatic drive_src(input logic r, s);
        logic [N-1:0] v, l;
        logic [N*W-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (q_sym[i].size() > 0) begin
                v[i] = 1'b1;
                l[i] = q_last[i][0];
                d[i*W +: W] = q_sym[i][0];
            end
        end
        drive(r, s, v, l, d);
        for (int i = 0; i < N; i++) begin
            if (cap_ready[i] && q_sym[i].size() > 0) begin
                void'(q_sym[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
    endtask

    task automatic push(input int c, input logic [W-1:0] s, input bit l);
        q_sym[c].push_back(s);
        q_last[c].push_back(l);
    endtask

    localparam logic [39:0] D0 = 40'h00_0000_0155;
    localparam logic [39:0] D1 = 40'h00_1010_0000;
    localparam logic [39:0] D2 = 40'h00_1020_0000;
    localparam logic [39:0] D3 = 40'h00_1030_0000;

    initial begin
        logic [W-1:0] seq3 [8];
        logic [W-1:0] exp3 [8];
        int ngr, nerr, seen3;
        int mode, pv;
        logic r, s;
        logic [N-1:0] v, l;
        logic [N*W-1:0] d;

        kchar = 8'hBC;
        rst = 1'b1; tx_strobe = 1'b0; ch_valid = '0; ch_last = '0; ch_data_in = '0;

        // Directed table: reset, idle strobes, ch2 3-symbol frame, gap, ch0 single symbol.
        tbl.push_back(mk(1'b1, 1'b1, 4'b0000, 4'b0000, 40'd0, 4'b0000, 10'h3BC, 2'd3, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 40'd0, 4'b0000, 10'h3BC, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0000, D1, 4'b0000, 10'h3BC, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0000, D1, 4'b0100, 10'h101, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0000, D2, 4'b0000, 10'h101, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0000, D2, 4'b0100, 10'h102, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0100, D3, 4'b0000, 10'h102, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, D3, 4'b0100, 10'h103, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 40'd0, 4'b0000, 10'h3BC, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0001, 4'b0001, D0, 4'b0000, 10'h3BC, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0001, D0, 4'b0000, 10'h3BC, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0001, D0, 4'b0001, 10'h155, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 40'd0, 4'b0000, 10'h3BC, 2'd0, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), {12'd0, cap_ready}, {12'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_dout", i), {6'd0, dout}, {6'd0, tbl[i].dout});
            chk($sformatf("tbl%0d_grant", i), {14'd0, gid}, {14'd0, tbl[i].gid});
            chk($sformatf("tbl%0d_busy", i), {15'd0, busy}, {15'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_uerr", i), {15'd0, uerr}, {15'd0, tbl[i].err});
        end

        // ch0 and ch1 request together: whole ch0 frame, two commas, then ch1.
        drive_src(1'b1, 1'b0);
        push(0, 10'h010, 1'b0); push(0, 10'h011, 1'b1);
        push(1, 10'h020, 1'b0); push(1, 10'h021, 1'b1);
        exp3[0] = 10'h010; exp3[1] = 10'h011; exp3[2] = 10'h3BC; exp3[3] = 10'h3BC;
        exp3[4] = 10'h020; exp3[5] = 10'h021; exp3[6] = 10'h3BC; exp3[7] = 10'h3BC;
        for (int i = 0; i < 8; i++) begin
            drive_src(1'b0, 1'b1);
            seq3[i] = dout;
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("pair_seq%0d", i), {6'd0, seq3[i]}, {6'd0, exp3[i]});

        // All channels busy with single-symbol frames: grants rotate 0,1,2,3.
        drive_src(1'b1, 1'b0);
        for (int c = 0; c < N; c++)
            for (int n = 0; n < 3; n++)
                push(c, 10'(10'h100 + c*16 + n), 1'b1);
        ngr = 0;
        for (int i = 0; i < 45; i++) begin
            drive_src(1'b0, 1'b1);
            if (cap_ready != '0) begin
                chk($sformatf("rr_order%0d", ngr), {14'd0, gid}, 16'(ngr % N));
                ngr++;
            end
        end
        chk("rr_count", 16'(ngr), 16'd12);

        // ch3 starts a frame then starves: one abort pulse, then re-arbitrated.
        drive_src(1'b1, 1'b0);
        push(3, 10'h333, 1'b0);
        nerr = 0;
        for (int i = 0; i < 12; i++) begin
            drive_src(1'b0, 1'b1);
            if (uerr) nerr++;
        end
        chk("underrun_pulses", 16'(nerr), 16'd1);
        push(3, 10'h334, 1'b1);
        seen3 = 0;
        for (int i = 0; i < 4; i++) begin
            drive_src(1'b0, 1'b1);
            if (cap_ready[3]) begin
                seen3++;
                chk("regrant_dout", {6'd0, dout}, 16'h0334);
                chk("regrant_gid", {14'd0, gid}, 16'd3);
            end
        end
        chk("regrant_seen", 16'(seen3), 16'd1);

        // Reset in the middle of a ch1 frame, then a fresh ch1 frame.
        drive_src(1'b1, 1'b0);
        push(1, 10'h111, 1'b0); push(1, 10'h112, 1'b0); push(1, 10'h113, 1'b1);
        drive_src(1'b0, 1'b1);
        drive_src(1'b0, 1'b1);
        chk("mid_busy", {15'd0, busy}, 16'd1);
        drive_src(1'b1, 1'b1);
        chk("rst_ready", {12'd0, cap_ready}, 16'd0);
        chk("rst_dout", {6'd0, dout}, 16'h03BC);
        chk("rst_gid", {14'd0, gid}, 16'd3);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_uerr", {15'd0, uerr}, 16'd0);
        drive_src(1'b0, 1'b1);
        chk("fresh_dout", {6'd0, dout}, 16'h0113);
        chk("fresh_gid", {14'd0, gid}, 16'd1);
        for (int i = 0; i < 3; i++) drive_src(1'b0, 1'b1);

        // Randomized traffic: strobe rate, request density, resets and comma changes.
        for (int seg = 0; seg < 6; seg++) begin
            mode = seg % 3;
            pv = (seg < 3) ? 75 : 12;
            for (int i = 0; i < 500; i++) begin
                r = ($urandom_range(0, 299) == 0);
                case (mode)
                    0: s = 1'b1;
                    1: s = $urandom_range(0, 1) == 1;
                    default: s = (i % 4 == 0);
                endcase
                for (int c = 0; c < N; c++) begin
                    v[c] = $urandom_range(0, 99) < pv;
                    l[c] = $urandom_range(0, 99) < 30;
                    d[c*W +: W] = W'($urandom);
                end
                if ($urandom_range(0, 63) == 0) kchar = 8'($urandom);
                drive(r, s, v, l, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
